// File: rtl/lut_seq_cell.sv
// lut_seq_cell: serially programmable N-input LUT with registered result, delay line, rise pulse and rise counter.
// Latency: x sampled at edge k -> y valid after edge k; y_dly trails y by DELAY edges; rise/rise_cnt align with y.
// Backpressure: none; the cell evaluates or shifts configuration on every clock edge.
//
// Ports:
//   io_in[0]   clk (rising edge)
//   io_in[1]   rst (synchronous, active-high, wins over everything)
//   io_in[2]   cfg_en  : 1 = shift cfg_bit into the truth table, 0 = evaluate
//   io_in[3]   cfg_bit : serial truth-table data, MSB first
//   io_in[7:4] x       : LUT operands, only io_in[4 +: N_IN] used
//   io_out[0]  y, io_out[1] y_dly, io_out[2] rise, io_out[7:3] rise_cnt
//
// Optional feature: define LUT_SEQ_CNT_SAT_EN to make rise_cnt saturate at 31
// instead of wrapping to 0.

module lut_seq_cell #(
    parameter int unsigned          N_IN     = 3,
    parameter logic [(1<<N_IN)-1:0] RESET_TT = 8'hEA,
    parameter int unsigned          DELAY    = 4
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam int unsigned TT_W = 1 << N_IN;

    logic            clk;
    logic            rst;
    logic            cfg_en;
    logic            cfg_bit;
    logic [N_IN-1:0] x;

    assign clk     = io_in[0];
    assign rst     = io_in[1];
    assign cfg_en  = io_in[2];
    assign cfg_bit = io_in[3];
    assign x       = io_in[4 +: N_IN];

    // Operand pins above N_IN are intentionally ignored.
    logic unused_io_in;
    assign unused_io_in = ^io_in[7:4];

    logic [TT_W-1:0]  tt_q, tt_d;
    logic             y_q, y_d;
    logic             y_prev_q, y_prev_d;
    logic [DELAY-1:0] dl_q, dl_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [4:0]       cnt_inc;
    logic             rise;

`ifdef LUT_SEQ_CNT_SAT_EN
    assign cnt_inc = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
`else
    assign cnt_inc = cnt_q + 5'd1;
`endif

    // Mode selection: configuration shifts the table and freezes y;
    // evaluation looks up the table and counts 0->1 transitions of y.
    always_comb begin
        tt_d  = tt_q;
        y_d   = y_q;
        cnt_d = cnt_q;
        if (cfg_en) begin
            tt_d = {tt_q[TT_W-2:0], cfg_bit};
        end else begin
            y_d = tt_q[x];
            // Count at the edge that loads the rising value, so the new count
            // becomes visible in the same cycle as the rise pulse.
            if (y_d && !y_q) begin
                cnt_d = cnt_inc;
            end
        end
    end

    // y_prev always tracks y, which keeps rise low while y is frozen.
    assign y_prev_d = y_q;

    // The delay line shifts in both modes; during configuration it shifts the held y.
    generate
        if (DELAY == 1) begin : g_dl_single
            assign dl_d = y_q;
        end else begin : g_dl_multi
            assign dl_d = {dl_q[DELAY-2:0], y_q};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            tt_q     <= RESET_TT;
            y_q      <= 1'b0;
            y_prev_q <= 1'b0;
            dl_q     <= '0;
            cnt_q    <= 5'd0;
        end else begin
            tt_q     <= tt_d;
            y_q      <= y_d;
            y_prev_q <= y_prev_d;
            dl_q     <= dl_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rise   = y_q & ~y_prev_q;
    assign io_out = {cnt_q, rise, dl_q[DELAY-1], y_q};

endmodule
